// File: rtl/traffic_lights_multi.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_multi
// Description : Round-robin traffic light controller for N_DIR approaches with
//               all-red clearance, programmable timing and uncontrolled mode.
//               Define TL_MULTI_STATUS_EN to add the phase_o/dir_o status ports.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lights_multi #(
    parameter int N_DIR                = 2,
    parameter int BLINK_HALF_PERIOD    = 5,
    parameter int GREEN_BLINKS_NUM     = 4,
    parameter int RED_YELLOW_TIME      = 5,
    parameter int ALL_RED_TIME_DEFAULT = 5,
    parameter int YELLOW_TIME_DEFAULT  = 5,
    parameter int GREEN_TIME_DEFAULT   = 5,
    localparam int DIR_W               = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [2:0]       cmd_type_i,
    input  logic             cmd_valid_i,
    input  logic [15:0]      cmd_data_i,
    input  logic [DIR_W-1:0] cmd_dir_i,
    output logic [N_DIR-1:0] red_o,
    output logic [N_DIR-1:0] yellow_o,
`ifdef TL_MULTI_STATUS_EN
    output logic [N_DIR-1:0] green_o,
    output logic [2:0]       phase_o,
    output logic [DIR_W-1:0] dir_o
`else
    output logic [N_DIR-1:0] green_o
`endif
);

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_ALL_RED     = 3'd1,
        ST_RED_YELLOW  = 3'd2,
        ST_GREEN       = 3'd3,
        ST_GREEN_BLINK = 3'd4,
        ST_YELLOW      = 3'd5,
        ST_UNCONTR     = 3'd6
    } state_t;

    localparam logic [2:0] c_cmd_turn_on      = 3'd0;
    localparam logic [2:0] c_cmd_turn_off     = 3'd1;
    localparam logic [2:0] c_cmd_set_uncontr  = 3'd2;
    localparam logic [2:0] c_cmd_set_green    = 3'd3;
    localparam logic [2:0] c_cmd_set_all_red  = 3'd4;
    localparam logic [2:0] c_cmd_set_yellow   = 3'd5;

    localparam logic [15:0] c_all_red_def = 16'(ALL_RED_TIME_DEFAULT);
    localparam logic [15:0] c_yellow_def  = 16'(YELLOW_TIME_DEFAULT);
    localparam logic [15:0] c_green_def   = 16'(GREEN_TIME_DEFAULT);
    localparam logic [15:0] c_ry_len      = (RED_YELLOW_TIME == 0) ? 16'd1 : 16'(RED_YELLOW_TIME);
    localparam logic [15:0] c_blink_len   = (BLINK_HALF_PERIOD == 0) ? 16'd1 : 16'(BLINK_HALF_PERIOD);
    localparam logic [15:0] c_blink_last  = (GREEN_BLINKS_NUM > 1) ? 16'(GREEN_BLINKS_NUM - 1) : 16'd0;
    localparam logic [DIR_W-1:0] c_last_dir  = DIR_W'(N_DIR - 1);
    localparam logic [DIR_W:0]   c_n_dir_ext = (DIR_W + 1)'(N_DIR);

    // A programmed duration of zero still shows the state for one cycle.
    function automatic logic [15:0] f_eff(input logic [15:0] t);
        return (t == 16'd0) ? 16'd1 : t;
    endfunction

    state_t            r_state;
    logic [DIR_W-1:0]  r_dir;
    logic [15:0]       r_cnt;
    logic [15:0]       r_half;
    logic [15:0]       r_len;
    logic [15:0]       r_all_red_time;
    logic [15:0]       r_yellow_time;
    logic [15:0]       r_green_time [N_DIR];
    logic [N_DIR-1:0]  r_red;
    logic [N_DIR-1:0]  r_yellow;
    logic [N_DIR-1:0]  r_green;

    state_t            w_state_nxt;
    logic [DIR_W-1:0]  w_dir_nxt;
    logic [15:0]       w_cnt_nxt;
    logic [15:0]       w_half_nxt;
    logic [15:0]       w_len_nxt;
    logic              w_enter;
    logic              w_done;
    logic [N_DIR-1:0]  w_sel;
    logic [N_DIR-1:0]  w_red_nxt;
    logic [N_DIR-1:0]  w_yellow_nxt;
    logic [N_DIR-1:0]  w_green_nxt;

    // r_len is latched on state entry, so a state in progress keeps its old length.
    assign w_done = (r_cnt == (r_len - 16'd1));
    assign w_sel  = N_DIR'(1) << w_dir_nxt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_all_red_time <= c_all_red_def;
            r_yellow_time  <= c_yellow_def;
            for (int i = 0; i < N_DIR; i++) begin
                r_green_time[i] <= c_green_def;
            end
        end else if (cmd_valid_i) begin
            case (cmd_type_i)
                c_cmd_set_green: begin
                    if ({1'b0, cmd_dir_i} < c_n_dir_ext) begin
                        r_green_time[cmd_dir_i] <= cmd_data_i;
                    end
                end
                c_cmd_set_all_red: r_all_red_time <= cmd_data_i;
                c_cmd_set_yellow:  r_yellow_time  <= cmd_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state  <= ST_ALL_RED;
            r_dir    <= '0;
            r_cnt    <= 16'd0;
            r_half   <= 16'd0;
            r_len    <= f_eff(c_all_red_def);
            r_red    <= '1;
            r_yellow <= '0;
            r_green  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_half   <= w_half_nxt;
            r_len    <= w_len_nxt;
            r_red    <= w_red_nxt;
            r_yellow <= w_yellow_nxt;
            r_green  <= w_green_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_cnt_nxt    = r_cnt + 16'd1;
        w_half_nxt   = r_half;
        w_len_nxt    = r_len;
        w_enter      = 1'b0;
        w_red_nxt    = '0;
        w_yellow_nxt = '0;
        w_green_nxt  = '0;

        case (r_state)
            ST_ALL_RED: begin
                if (w_done) begin
                    w_state_nxt = ST_RED_YELLOW;
                    w_enter     = 1'b1;
                end
            end
            ST_RED_YELLOW: begin
                if (w_done) begin
                    w_state_nxt = ST_GREEN;
                    w_enter     = 1'b1;
                end
            end
            ST_GREEN: begin
                if (w_done) begin
                    w_state_nxt = ST_GREEN_BLINK;
                    w_enter     = 1'b1;
                end
            end
            ST_GREEN_BLINK: begin
                if (w_done) begin
                    if (r_half >= c_blink_last) begin
                        w_state_nxt = ST_YELLOW;
                        w_enter     = 1'b1;
                    end else begin
                        w_half_nxt = r_half + 16'd1;
                        w_cnt_nxt  = 16'd0;
                    end
                end
            end
            ST_YELLOW: begin
                if (w_done) begin
                    w_state_nxt = ST_ALL_RED;
                    w_dir_nxt   = (r_dir == c_last_dir) ? '0 : r_dir + DIR_W'(1);
                    w_enter     = 1'b1;
                end
            end
            ST_UNCONTR: begin
                if (w_done) begin
                    w_cnt_nxt  = 16'd0;
                    w_half_nxt = {15'd0, ~r_half[0]};
                end
            end
            default: w_cnt_nxt = r_cnt;
        endcase

        // Mode commands override the normal sequencing in any state.
        if (cmd_valid_i) begin
            case (cmd_type_i)
                c_cmd_turn_on: begin
                    w_state_nxt = ST_ALL_RED;
                    w_dir_nxt   = '0;
                    w_enter     = 1'b1;
                end
                c_cmd_turn_off: begin
                    w_state_nxt = ST_OFF;
                    w_enter     = 1'b1;
                end
                c_cmd_set_uncontr: begin
                    w_state_nxt = ST_UNCONTR;
                    w_enter     = 1'b1;
                end
                default: ;
            endcase
        end

        if (w_enter) begin
            w_cnt_nxt  = 16'd0;
            w_half_nxt = 16'd0;
            case (w_state_nxt)
                ST_ALL_RED:                 w_len_nxt = f_eff(r_all_red_time);
                ST_RED_YELLOW:              w_len_nxt = c_ry_len;
                ST_GREEN:                   w_len_nxt = f_eff(r_green_time[w_dir_nxt]);
                ST_GREEN_BLINK, ST_UNCONTR: w_len_nxt = c_blink_len;
                ST_YELLOW:                  w_len_nxt = f_eff(r_yellow_time);
                default:                    w_len_nxt = 16'd1;
            endcase
        end

        // Lamps are decoded from the next state so they register together with it.
        case (w_state_nxt)
            ST_ALL_RED: w_red_nxt = '1;
            ST_RED_YELLOW: begin
                w_red_nxt    = '1;
                w_yellow_nxt = w_sel;
            end
            ST_GREEN: begin
                w_red_nxt   = ~w_sel;
                w_green_nxt = w_sel;
            end
            ST_GREEN_BLINK: begin
                w_red_nxt   = ~w_sel;
                w_green_nxt = w_half_nxt[0] ? w_sel : '0;
            end
            ST_YELLOW: begin
                w_red_nxt    = ~w_sel;
                w_yellow_nxt = w_sel;
            end
            ST_UNCONTR: w_yellow_nxt = w_half_nxt[0] ? '0 : '1;
            default: ;
        endcase
    end

    assign red_o    = r_red;
    assign yellow_o = r_yellow;
    assign green_o  = r_green;

`ifdef TL_MULTI_STATUS_EN
    assign phase_o = r_state;
    assign dir_o   = r_dir;
`endif

endmodule
`default_nettype wire
